mem_port_arbiter: RTL and testbench

- Parametrised N-port memory arbiter between the cpu_core instances and the single external memory read/write channel; the next generation of the CPU-top port wiring.
- Scales to CORE cores (RPORT = 2*CORE read clients, WPORT = CORE write clients).
- Independent round-robin read and write arbiters, each with a registered request/ack FSM.
- Read-after-write ordering guard: a read never overtakes an in-flight write to the same word.

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin multi-client read/write arbiter onto a single memory channel,
// with a word-granular guard that keeps reads from overtaking in-flight writes.
module mem_port_arbiter #(
  parameter int RPORT  = 2,
  parameter int WPORT  = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RPORT-1:0]          c_re,
  input  logic [RPORT*ADDR_W-1:0]   c_raddr,
  input  logic [RPORT*LEN_W-1:0]    c_rlen,
  output logic [RPORT*DATA_W-1:0]   c_rdata,
  output logic [RPORT-1:0]          c_rack,
  input  logic [WPORT-1:0]          c_we,
  input  logic [WPORT*ADDR_W-1:0]   c_waddr,
  input  logic [WPORT*LEN_W-1:0]    c_wlen,
  input  logic [WPORT*DATA_W-1:0]   c_wdata,
  output logic [WPORT-1:0]          c_wack,
  output logic                      m_re,
  output logic [ADDR_W-1:0]         m_raddr,
  output logic [LEN_W-1:0]          m_rlen,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic                      m_rack,
  output logic                      m_we,
  output logic [ADDR_W-1:0]         m_waddr,
  output logic [LEN_W-1:0]          m_wlen,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic                      m_wack
);
  localparam int RW = RPORT > 1 ? $clog2(RPORT) : 1;
  localparam int WW = WPORT > 1 ? $clog2(WPORT) : 1;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
  r_state_t r_rstate, w_rnext;
  w_state_t r_wstate, w_wnext;
  logic [RW-1:0] r_rptr, r_rg, w_rcand;
  logic [WW-1:0] r_wptr, r_wg, w_wcand;
  logic w_rfound, w_wfound, w_rgrant, w_wgrant, w_conflict;
  logic [ADDR_W-1:0] w_rcaddr, w_wcaddr, r_raddr, r_waddr;
  logic [LEN_W-1:0] r_rlen, r_wlen;
  logic [DATA_W-1:0] r_wdata;
  logic [RPORT*DATA_W-1:0] r_rdata;
  // Search starts one past the last granted client so every requester gets a turn.
  always_comb begin
    w_rfound = 1'b0;
    w_rcand = '0;
    for (int k = 1; k <= RPORT; k++)
      if (!w_rfound && c_re[RW'((int'(r_rptr) + k) % RPORT)]) begin
        w_rfound = 1'b1;
        w_rcand = RW'((int'(r_rptr) + k) % RPORT);
      end
    w_wfound = 1'b0;
    w_wcand = '0;
    for (int k = 1; k <= WPORT; k++)
      if (!w_wfound && c_we[WW'((int'(r_wptr) + k) % WPORT)]) begin
        w_wfound = 1'b1;
        w_wcand = WW'((int'(r_wptr) + k) % WPORT);
      end
    w_rcaddr = c_raddr[int'(w_rcand)*ADDR_W +: ADDR_W];
    w_wcaddr = c_waddr[int'(w_wcand)*ADDR_W +: ADDR_W];
    w_wgrant = r_wstate == W_IDLE && w_wfound;
    w_conflict = (r_wstate != W_IDLE && w_rcaddr[ADDR_W-1:2] == r_waddr[ADDR_W-1:2]) ||
                 (w_wgrant && w_rcaddr[ADDR_W-1:2] == w_wcaddr[ADDR_W-1:2]);
    w_rgrant = r_rstate == R_IDLE && w_rfound && !w_conflict;
  end
  always_comb begin
    w_rnext = r_rstate == R_IDLE ? (w_rgrant ? R_REQ : R_IDLE) :
              r_rstate == R_REQ  ? (m_rack ? R_RESP : R_REQ) : R_IDLE;
    w_wnext = r_wstate == W_IDLE ? (w_wgrant ? W_REQ : W_IDLE) :
              r_wstate == W_REQ  ? (m_wack ? W_RESP : W_REQ) : W_IDLE;
    m_re = r_rstate == R_REQ;
    m_we = r_wstate == W_REQ;
    c_rack = r_rstate == R_RESP ? RPORT'(1) << r_rg : '0;
    c_wack = r_wstate == W_RESP ? WPORT'(1) << r_wg : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
    end else begin
      r_rstate <= w_rnext;
      r_wstate <= w_wnext;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr  <= '0;
      r_rg    <= '0;
      r_raddr <= '0;
      r_rlen  <= '0;
      r_rdata <= '0;
      r_wptr  <= '0;
      r_wg    <= '0;
      r_waddr <= '0;
      r_wlen  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_rgrant) begin
        r_rptr  <= w_rcand;
        r_rg    <= w_rcand;
        r_raddr <= w_rcaddr;
        r_rlen  <= c_rlen[int'(w_rcand)*LEN_W +: LEN_W];
      end
      if (r_rstate == R_REQ && m_rack)
        r_rdata[int'(r_rg)*DATA_W +: DATA_W] <= m_rdata;
      if (w_wgrant) begin
        r_wptr  <= w_wcand;
        r_wg    <= w_wcand;
        r_waddr <= w_wcaddr;
        r_wlen  <= c_wlen[int'(w_wcand)*LEN_W +: LEN_W];
        r_wdata <= c_wdata[int'(w_wcand)*DATA_W +: DATA_W];
      end
    end
  end
  assign c_rdata = r_rdata;
  assign m_raddr = r_raddr;
  assign m_rlen  = r_rlen;
  assign m_waddr = r_waddr;
  assign m_wlen  = r_wlen;
  assign m_wdata = r_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus randomized checks of arbitration order, data return,
// read-after-write blocking, spurious acks and reset abort against a behavioural memory model.
module tb_mem_port_arbiter;
  localparam int RP = 4, WP = 2, AW = 32, DW = 32, LW = 2;
  logic clk = 1'b0;
  logic rst;
  logic [RP-1:0] c_re;
  logic [RP*AW-1:0] c_raddr;
  logic [RP*LW-1:0] c_rlen;
  logic [RP*DW-1:0] c_rdata;
  logic [RP-1:0] c_rack;
  logic [WP-1:0] c_we;
  logic [WP*AW-1:0] c_waddr;
  logic [WP*LW-1:0] c_wlen;
  logic [WP*DW-1:0] c_wdata;
  logic [WP-1:0] c_wack;
  logic m_re, m_rack, m_we, m_wack;
  logic [AW-1:0] m_raddr, m_waddr;
  logic [LW-1:0] m_rlen, m_wlen;
  logic [DW-1:0] m_rdata, m_wdata;
  int checks = 0, failures = 0;
  int rdelay, wdelay;
  bit spur;
  logic [31:0] mem [logic [29:0]];
  logic [31:0] exp_rdata [RP];
  logic [31:0] raddr_q [RP];
  logic [31:0] wdata_q [WP];
  logic [31:0] waddr_q [WP];
  int exp_rptr, exp_wptr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RPORT(RP), .WPORT(WP), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .c_re(c_re), .c_raddr(c_raddr), .c_rlen(c_rlen), .c_rdata(c_rdata), .c_rack(c_rack),
    .c_we(c_we), .c_waddr(c_waddr), .c_wlen(c_wlen), .c_wdata(c_wdata), .c_wack(c_wack),
    .m_re(m_re), .m_raddr(m_raddr), .m_rlen(m_rlen), .m_rdata(m_rdata), .m_rack(m_rack),
    .m_we(m_we), .m_waddr(m_waddr), .m_wlen(m_wlen), .m_wdata(m_wdata), .m_wack(m_wack)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    if (a[31:2] == 30'h40) return 32'hDEADBEEF;
    return {a[31:2], 2'b00} ^ 32'h13579BDF;
  endfunction

  function automatic int rr_next(input int ptr, input logic [3:0] req, input int n);
    for (int k = 1; k <= n; k++)
      if (req[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  function automatic logic [RP*DW-1:0] pack_rd();
    logic [RP*DW-1:0] p;
    for (int i = 0; i < RP; i++) p[i*DW +: DW] = exp_rdata[i];
    return p;
  endfunction

  // Memory responder: acks after a programmable number of strobe cycles, stores writes.
  initial begin
    int rcnt, wcnt;
    rcnt = 0;
    wcnt = 0;
    m_rack = 1'b0;
    m_wack = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (m_rack) m_rack = 1'b0;
      else if (m_re) begin
        rcnt++;
        if (rcnt >= rdelay) begin
          m_rack = 1'b1;
          m_rdata = mem_rd(m_raddr);
          rcnt = 0;
        end
      end else rcnt = 0;
      if (m_wack) m_wack = 1'b0;
      else if (m_we) begin
        wcnt++;
        if (wcnt >= wdelay) begin
          m_wack = 1'b1;
          mem[m_waddr[31:2]] = m_wdata;
          wcnt = 0;
        end
      end else wcnt = 0;
      if (spur) begin
        m_rack = 1'b1;
        m_wack = 1'b1;
        m_rdata = 32'hBAD0BAD0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input bit wr, output int idx, output int cyc);
    logic [3:0] v;
    idx = -1;
    cyc = 0;
    while (idx < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      v = wr ? {2'b00, c_wack} : c_rack;
      if (v != 0) begin
        checks++;
        assert ($onehot(v)) else begin
          failures++;
          $error("FAIL ack_onehot obs=%b exp=onehot", v);
        end
        for (int i = 0; i < 4; i++) if (v[i]) idx = i;
      end
    end
    checks++;
    assert (idx >= 0) else begin
      failures++;
      $error("FAIL %s_timeout obs=none exp=ack_within_300", wr ? "wack" : "rack");
    end
    if (idx < 0) idx = 0;
  endtask

  task automatic set_read(input int i, input logic [31:0] a, input logic [1:0] len);
    c_raddr[i*AW +: AW] = a;
    c_rlen[i*LW +: LW] = len;
    raddr_q[i] = a;
    c_re[i] = 1'b1;
  endtask

  task automatic set_write(input int i, input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
    c_waddr[i*AW +: AW] = a;
    c_wlen[i*LW +: LW] = len;
    c_wdata[i*DW +: DW] = d;
    waddr_q[i] = a;
    wdata_q[i] = d;
    c_we[i] = 1'b1;
  endtask

  task automatic read_done(input int exp_idx, input bit drop);
    int idx, cyc;
    wait_ack(1'b0, idx, cyc);
    chk("rack_idx", idx, exp_idx);
    if (drop) c_re[idx] = 1'b0;
    exp_rdata[exp_idx] = mem_rd(raddr_q[exp_idx]);
    exp_rptr = exp_idx;
    chk("rdata_bus", c_rdata, pack_rd());
  endtask

  task automatic write_block_read(input int exp_w);
    bit early, got;
    early = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      early |= m_re;
      got = |c_wack;
    end
    chk("wack_seen", got, 1'b1);
    chk("raw_blocked", early, 1'b0);
    chk("wack_vec", c_wack, 2'b01 << exp_w);
    c_we = '0;
    exp_wptr = exp_w;
  endtask

  initial begin
    int idx, cyc, e;
    int cnt [RP];
    bit seen;
    rst = 1'b1;
    c_re = '0; c_raddr = '0; c_rlen = '0;
    c_we = '0; c_waddr = '0; c_wlen = '0; c_wdata = '0;
    rdelay = 1; wdelay = 1; spur = 1'b0;
    exp_rptr = 0; exp_wptr = 0;
    for (int i = 0; i < RP; i++) begin exp_rdata[i] = '0; raddr_q[i] = '0; cnt[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_strobes", {m_re, m_we}, 2'b00);
    chk("rst_acks", {c_rack, c_wack}, '0);
    chk("rst_rdata", c_rdata, '0);
    chk("rst_maddr", {m_raddr, m_waddr, m_wdata}, '0);
    rst = 1'b0;
    // Single read of 0x100, memory answers 2 cycles after the strobe
    @(negedge clk);
    rdelay = 2;
    set_read(0, 32'h100, 2'd2);
    @(negedge clk);
    chk("rd_strobe", {m_re, m_raddr, m_rlen}, {1'b1, 32'h100, 2'd2});
    c_raddr[0 +: AW] = 32'h999;
    wait_ack(1'b0, idx, cyc);
    chk("rd_latency", cyc + 1, rdelay + 1);
    chk("rd_idx", idx, 0);
    c_re[0] = 1'b0;
    exp_rdata[0] = 32'hDEADBEEF;
    exp_rptr = 0;
    chk("rd_data", c_rdata, pack_rd());
    @(negedge clk);
    chk("rack_pulse", c_rack, 4'b0000);
    // All readers held high: round-robin order with random addresses and memory delays
    for (int i = 0; i < RP; i++) set_read(i, {$urandom_range(16'h0, 16'hFFFF), 2'b00}, 2'($urandom_range(0, 2)));
    for (int t = 0; t < 8; t++) begin
      rdelay = $urandom_range(1, 4);
      e = rr_next(exp_rptr, c_re, RP);
      read_done(e, t == 7);
      cnt[e]++;
      if (t == 7) c_re = '0;
      else set_read(e, {$urandom_range(16'h0, 16'hFFFF), 2'b00}, 2'($urandom_range(0, 2)));
    end
    for (int i = 0; i < RP; i++) chk("rr_fair", cnt[i], 2);
    repeat (2) @(negedge clk);
    // Same-word write and read raised together: write first, read after the write ack
    rdelay = 1; wdelay = 2;
    set_write(0, 32'h200, 2'd2, $urandom);
    set_read(1, 32'h200, 2'd2);
    @(negedge clk);
    chk("raw_order", {m_we, m_re, m_waddr}, {1'b1, 1'b0, 32'h200});
    write_block_read(rr_next(exp_wptr, 4'b0001, WP));
    read_done(1, 1'b1);
    chk("raw_data", c_rdata[1*DW +: DW], wdata_q[0]);
    repeat (2) @(negedge clk);
    // Different words proceed concurrently
    rdelay = 3; wdelay = 1;
    set_write(1, 32'h200, 2'd2, $urandom);
    set_read(2, 32'h300, 2'd2);
    @(negedge clk);
    chk("concurrent", {m_re, m_we}, 2'b11);
    wait_ack(1'b1, idx, cyc);
    chk("wack_idx", idx, rr_next(exp_wptr, 4'b0010, WP));
    exp_wptr = 1;
    c_we = '0;
    read_done(rr_next(exp_rptr, 4'b0100, RP), 1'b1);
    repeat (3) @(negedge clk);
    // Spurious memory acks while both sides idle
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= |{c_rack, c_wack, m_re, m_we};
    end
    chk("spur_quiet", seen, 1'b0);
    chk("spur_rdata", c_rdata, pack_rd());
    // Byte write to 0x203 blocks a read of word 0x200
    wdelay = 4; rdelay = 1;
    set_write(0, 32'h203, 2'd0, 32'hAB);
    @(negedge clk);
    chk("wr_fields", {m_we, m_waddr, m_wlen, m_wdata}, {1'b1, 32'h203, 2'd0, 32'hAB});
    set_read(3, 32'h200, 2'd2);
    write_block_read(rr_next(exp_wptr, 4'b0001, WP));
    read_done(rr_next(exp_rptr, 4'b1000, RP), 1'b1);
    chk("byte_raw_data", c_rdata[3*DW +: DW], 32'hAB);
    repeat (2) @(negedge clk);
    // Both writers held high: alternating grants, data latched at grant
    set_write(0, 32'h8000 + {$urandom_range(0, 255), 2'b00}, 2'd2, $urandom);
    set_write(1, 32'h9000 + {$urandom_range(0, 255), 2'b00}, 2'd2, $urandom);
    for (int t = 0; t < 4; t++) begin
      wdelay = $urandom_range(1, 3);
      e = rr_next(exp_wptr, {2'b00, c_we}, WP);
      wait_ack(1'b1, idx, cyc);
      chk("wrr_idx", idx, e);
      chk("wrr_data", mem[waddr_q[e][31:2]], wdata_q[e]);
      exp_wptr = e;
      if (t == 3) c_we = '0;
      else begin
        wdata_q[e] = $urandom;
        c_wdata[e*DW +: DW] = wdata_q[e];
      end
    end
    repeat (3) @(negedge clk);
    // Reset in the middle of a read request
    rdelay = 50;
    set_read(0, 32'h400, 2'd2);
    @(negedge clk);
    chk("pre_rst_mre", m_re, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst", {m_re, c_rack}, '0);
    chk("rst_rdata_clr", c_rdata, '0);
    @(negedge clk);
    chk("rst_hold", {m_re, m_we, c_rack, c_wack}, '0);
    c_re = '0;
    rst = 1'b0;
    for (int i = 0; i < RP; i++) exp_rdata[i] = '0;
    exp_rptr = 0;
    exp_wptr = 0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= |c_rack;
    end
    chk("no_ack_after_rst", seen, 1'b0);
    rdelay = 1;
    for (int i = 0; i < RP; i++) set_read(i, 32'h500 + 32'(i * 4), 2'd2);
    read_done(rr_next(exp_rptr, 4'b1111, RP), 1'b0);
    c_re = '0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
